// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling geometry and the bit-vote helper.
// Used by the receiver today; the sender is meant to adopt it as well.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Flop-chain synchroniser for the asynchronous RX pin; latency STAGES cycles, no flow control.
// Resets to all ones so an idle line never looks like a start bit after reset.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic rx_s_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], rx_i};
    end
  end

  assign rx_s_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver on a 16x baud clock; byte strobe 154 + SYNC_STAGES cycles after the start edge.
// No backpressure: rx_data is overwritten by the next good frame, so it must be taken within 160 cycles.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 baudclk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_status,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] TICK_LO   = CNT_W'(SAMPLE_LO);
  localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(SAMPLE_LO + 1);
  localparam logic [CNT_W-1:0] TICK_HI   = CNT_W'(SAMPLE_HI);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_s;
  logic vote;

  uart_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [BIT_W-1:0]     bitn_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_status_q;
  logic                 frame_err_q;
  logic                 rx_busy_q;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (baudclk),
    .reset_i (reset),
    .rx_i    (uart_rx),
    .rx_s_o  (rx_s)
  );

  // Two registered samples plus the live one give the 7/8/9 vote at tick 9.
  assign vote  = majority3(samp_q[0], samp_q[1], rx_s);
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge baudclk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shreg_q     <= '0;
      samp_q      <= 2'b11;
      rx_data_q   <= '0;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= cnt_d;

      if (cnt_q == TICK_LO) begin
        samp_q[0] <= rx_s;
      end
      if (cnt_q == TICK_MID) begin
        samp_q[1] <= rx_s;
      end

      case (state_q)
        IDLE: begin
          // The detection cycle is tick 0, so the frame starts counting at 1.
          cnt_q <= CNT_W'(1);
          if (!rx_s) begin
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == TICK_HI && vote) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end else if (cnt_q == TICK_LAST) begin
            state_q <= DATA;
            bitn_q  <= '0;
          end
        end

        DATA: begin
          if (cnt_q == TICK_HI) begin
            shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
          end
          if (cnt_q == TICK_LAST) begin
            if (bitn_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bitn_q <= bitn_q + 1'b1;
            end
          end
        end

        STOP: begin
          // Leaving at mid-stop-bit leaves slack for a slightly fast sender.
          if (cnt_q == TICK_HI) begin
            if (vote) begin
              rx_data_q   <= shreg_q;
              rx_status_q <= 1'b1;
              state_q     <= IDLE;
              rx_busy_q   <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_status = rx_status_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

  a_strobes_exclusive : assert property (@(posedge baudclk) disable iff (reset)
    !(rx_status_q && frame_err_q));

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path that pairs with the team's UART sender. It runs on the 16× oversampled `baudclk` and recovers 8N1 frames: one start bit (0), 8 data bits LSB first, and one stop bit (1), each bit lasting 16 `baudclk` cycles. It synchronises the asynchronous `uart_rx` line, rejects start-bit glitches, majority-votes each bit and presents each good byte with a one-cycle strobe. It sits between the board RX pin and the CPU-side peripheral register logic.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `uart_rx`; legal values are 2 or 3.
- `baudclk`  in  1: the only clock, 16× baud rate.
- `reset`  in  1: synchronous, active-high reset.
- `uart_rx`  in  1: asynchronous serial line; idles at 1.
- `rx_data`  out  8: last correctly framed byte. Reset value is 8'h00. Updates only on a good frame.
- `rx_status`  out  1: one-cycle pulse when `rx_data` has just been updated. Reset value is 0.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled as 0. Reset value is 0.
- `rx_busy`  out  1: high whenever state is not IDLE. Reset value is 0.

## Operation
- The synchroniser chain resets to all 1s. `rx_s` is the last stage. All FSM decisions use `rx_s` only.
- State encoding is IDLE, START, DATA, STOP, WAIT_HIGH.
- `cnt` is a 4-bit tick counter and wraps 15→0. `bitn` is a 3-bit data-bit index.
- `vote` is the majority of the three `rx_s` samples taken at `cnt` = 7, 8 and 9. The decision is made at `cnt` = 9.
- IDLE: when `rx_s`==0, go to START with `cnt`←1. The detection cycle counts as tick 0.
- START: at `cnt`==9, if `vote`==1 the start bit was a glitch; return to IDLE with no output. Otherwise stay in START. At `cnt`==15, go to DATA with `bitn`←0.
- DATA:
  - At `cnt`==9, shift `vote` into the MSB of `shreg` (right shift), so bit 0 ends up in `shreg[0]`.
  - At `cnt`==15: if `bitn`==7, go to STOP; otherwise `bitn`←`bitn`+1.
- STOP, at `cnt`==9:
  - `vote`==1: `rx_data`←`shreg`, pulse `rx_status`, go to IDLE. Returning at mid-stop-bit tolerates a sender that is up to about 3% fast.
  - `vote`==0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This stops a break condition from retriggering as a new start bit.
- `rx_status` and `frame_err` are never high in the same cycle.
- Reset at any point, including mid-frame, restores all reset values on the next edge and discards the partial byte.
- No holding buffer and no overrun detection: the consumer must capture `rx_data` within one frame time (160 cycles).

## Timing
- Let cycle 0 be the first `baudclk` edge at which `rx_s` samples 0, i.e. `SYNC_STAGES` edges after `uart_rx` falls.
- Data bit k is decided at tick 16(k+1)+9.
- The stop bit is decided at tick 153. `rx_status` or `frame_err` is high during cycle 154.
- Latency from the `uart_rx` falling edge to `rx_status` is 154 + `SYNC_STAGES` cycles, i.e. 156 with the default.
- `rx_busy` goes high in cycle 1. For a good frame it goes low in cycle 154.
- A new start edge is accepted from cycle 154 onward, so back-to-back frames with a 16-cycle stop bit are received without loss.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - `OVERSAMPLE`=16, `SAMPLE_LO`=7, `SAMPLE_HI`=9;
  - `DATA_BITS`=8.
- The sender migrates to this package later.
- One sub-module, `uart_rx_sync`: a parameterised flop chain with reset value 1.
- Voting, FSM and output registers live in `uart_receiver`.

## Test plan
- Sender-format frame for 8'hA5 driven at 16 cycles per bit → `rx_data`=8'hA5 and a one-cycle `rx_status` at 156 cycles after the falling edge. `frame_err` stays 0.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap → three `rx_status` pulses, 160 cycles apart, with matching `rx_data`.
- Low glitch of 5 cycles on an idle line → return to IDLE at tick 9. No strobes, `rx_data` unchanged, `rx_busy` high for 9 cycles.
- Frame 8'h81 with the stop bit forced to 0 and the line held low for 40 more cycles → `frame_err` pulse at cycle 154. `rx_data` keeps its old value. No new frame starts until the line returns high.
- Single-cycle inverted spikes at tick 8 of every data bit of 8'h5A → still 8'h5A, because the majority vote rejects them.
- `reset` asserted at tick 70 of a frame, then a clean 8'h42 frame → all outputs at reset values the cycle after, then 8'h42 received correctly.
